ram_loader: RTL and testbench

- Upstream write-side feeder for the 8-entry, 32-bit, byte-selectable RAM.
- Accepts a byte stream over a valid/ready handshake and packs it into little-endian 32-bit words.
- Drives the RAM's WR_ADDR / WR_DATA / WR_EN / BYTE_SELECT so the memory can be programmed from a narrow source.
- A trailing partial word is written with only the filled byte lanes enabled.

---
 rtl/ram_pkg.sv | 16 +
 rtl/byte_lane_packer.sv | 55 +++++
 rtl/ram_loader.sv | 130 +++++++++++++
 tb/tb_ram_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared constants and state encoding for the 8-entry byte-selectable RAM
// and its write-side loader.
package ram_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int DATA_W         = 32;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/byte_lane_packer.sv
// Byte-to-word packer: lane counter, data shift-in and byte-select mask.
// Define RAM_LOADER_BSWAP_EN to fill lanes from 3 downward (big-endian order).
module byte_lane_packer
    import ram_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_i,
    input  logic                      load_i,
    input  logic [7:0]                byte_i,
    output logic [DATA_W-1:0]         data_o,
    output logic [BYTES_PER_WORD-1:0] sel_o,
    output logic                      lane_full_o
);

    logic [LANE_W-1:0]         lane_q, lane_d;
    logic [LANE_W-1:0]         phys_lane;
    logic [DATA_W-1:0]         data_q, data_d;
    logic [BYTES_PER_WORD-1:0] sel_q, sel_d;

`ifdef RAM_LOADER_BSWAP_EN
    assign phys_lane = LANE_W'(BYTES_PER_WORD - 1) - lane_q;
`else
    assign phys_lane = lane_q;
`endif

    // lane_q counts bytes taken; the word is complete once the last slot fills
    assign lane_full_o = (lane_q == LANE_W'(BYTES_PER_WORD - 1));

    assign lane_d = clear_i ? '0 : (load_i ? lane_q + LANE_W'(1) : lane_q);

    // Unwritten lanes keep stale data; only the mask says which bytes are real
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
        logic hit;
        assign hit = load_i && (phys_lane == LANE_W'(gi));
        assign data_d[gi*8 +: 8] = hit ? byte_i : data_q[gi*8 +: 8];
        assign sel_d[gi]         = clear_i ? 1'b0 : (hit ? 1'b1 : sel_q[gi]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            data_q <= '0;
            sel_q  <= '0;
        end else begin
            lane_q <= lane_d;
            data_q <= data_d;
            sel_q  <= sel_d;
        end
    end

    assign data_o = data_q;
    assign sel_o  = sel_q;

endmodule

// File: rtl/ram_loader.sv
// Packs a valid/ready byte stream into 32-bit words and writes them to the RAM.
// Optional macro RAM_LOADER_BSWAP_EN selects big-endian lane order in the packer.
module ram_loader
    import ram_pkg::*;
#(
    parameter int ADDR_W    = 3,
    parameter int BASE_ADDR = 0
) (
    input  logic                      WR_CLK,
    input  logic                      ARST_N,
    input  logic                      START,
    input  logic [7:0]                IN_BYTE,
    input  logic                      IN_VALID,
    input  logic                      IN_LAST,
    output logic                      IN_READY,
    output logic [ADDR_W-1:0]         WR_ADDR,
    output logic [DATA_W-1:0]         WR_DATA,
    output logic                      WR_EN,
    output logic [BYTES_PER_WORD-1:0] BYTE_SELECT,
    output logic [ADDR_W:0]           WORD_COUNT,
    output logic                      DONE,
    output logic                      OVERFLOW
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wr_en_q, wr_en_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              last_q, last_d;

    logic handshake;
    logic pack_clear;
    logic lane_full;

    assign handshake = IN_VALID && (state_q == ST_FILL);

    byte_lane_packer u_packer (
        .clk         (WR_CLK),
        .rst_n       (ARST_N),
        .clear_i     (pack_clear),
        .load_i      (handshake),
        .byte_i      (IN_BYTE),
        .data_o      (WR_DATA),
        .sel_o       (BYTE_SELECT),
        .lane_full_o (lane_full)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        wr_en_d    = wr_en_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        last_d     = last_q;
        pack_clear = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d    = ST_FILL;
                    addr_d     = BASE;
                    count_d    = '0;
                    done_d     = 1'b0;
                    ovf_d      = 1'b0;
                    last_d     = 1'b0;
                    pack_clear = 1'b1;
                end
            end
            ST_FILL: begin
                if (handshake && (lane_full || IN_LAST)) begin
                    state_d = ST_WRITE;
                    wr_en_d = 1'b1;
                    last_d  = IN_LAST;
                end
            end
            ST_WRITE: begin
                wr_en_d    = 1'b0;
                pack_clear = 1'b1;
                count_d    = count_q + 1'b1;
                if (last_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (addr_q == LAST_ADDR) begin
                    // RAM full: stop rather than wrap onto already-written words
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    state_d = ST_FILL;
                    addr_d  = addr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge WR_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE;
            count_q <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
        end
    end

    assign IN_READY   = (state_q == ST_FILL);
    assign WR_ADDR    = addr_q;
    assign WR_EN      = wr_en_q;
    assign WORD_COUNT = count_q;
    assign DONE       = done_q;
    assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: directed and random byte streams
// compared against a word-level model of the packing rules.
module tb_ram_loader;

    logic        WR_CLK = 1'b0;
    logic        ARST_N = 1'b0;
    logic        START = 1'b0;
    logic [7:0]  IN_BYTE = 8'h00;
    logic        IN_VALID = 1'b0;
    logic        IN_LAST = 1'b0;
    logic        IN_READY;
    logic [2:0]  WR_ADDR;
    logic [31:0] WR_DATA;
    logic        WR_EN;
    logic [3:0]  BYTE_SELECT;
    logic [3:0]  WORD_COUNT;
    logic        DONE;
    logic        OVERFLOW;

    ram_loader #(.ADDR_W(3), .BASE_ADDR(0)) dut (
        .WR_CLK      (WR_CLK),
        .ARST_N      (ARST_N),
        .START       (START),
        .IN_BYTE     (IN_BYTE),
        .IN_VALID    (IN_VALID),
        .IN_LAST     (IN_LAST),
        .IN_READY    (IN_READY),
        .WR_ADDR     (WR_ADDR),
        .WR_DATA     (WR_DATA),
        .WR_EN       (WR_EN),
        .BYTE_SELECT (BYTE_SELECT),
        .WORD_COUNT  (WORD_COUNT),
        .DONE        (DONE),
        .OVERFLOW    (OVERFLOW)
    );

    always #5 WR_CLK = ~WR_CLK;

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } wr_t;

    wr_t        obs_q[$];
    wr_t        exp_q[$];
    logic [7:0] stim_q[$];
    int         exp_ovf;
    int         n_tests = 0;
    int         n_fail = 0;

    always @(negedge WR_CLK) begin
        if (ARST_N && WR_EN)
            obs_q.push_back('{addr: WR_ADDR, data: WR_DATA, sel: BYTE_SELECT});
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[k*8 +: 8] = {8{sel[k]}};
        return m;
    endfunction

    // Word-level model: chop the accepted bytes into 4-byte words, stop on
    // IN_LAST or once all 8 RAM words have been written.
    task automatic build_exp(input int n, input int last_idx);
        int          lane;
        int          words;
        int          pl;
        logic [31:0] word;
        logic [3:0]  sel;
        lane = 0; words = 0; word = '0; sel = '0; exp_ovf = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
`ifdef RAM_LOADER_BSWAP_EN
            pl = 3 - lane;
`else
            pl = lane;
`endif
            word[pl*8 +: 8] = stim_q[i];
            sel[pl] = 1'b1;
            if (lane == 3 || i == last_idx) begin
                exp_q.push_back('{addr: 3'(words), data: word, sel: sel});
                words++;
                lane = 0;
                sel = '0;
                if (i == last_idx) break;
                if (words == 8) begin
                    exp_ovf = 1;
                    break;
                end
            end else begin
                lane++;
            end
        end
    endtask

    task automatic do_load(input string name, input int last_idx, input bit gaps, input int start_at);
        int n;
        int idx;
        int cyc;
        bit acc;
        n = stim_q.size();
        build_exp(n, last_idx);
        obs_q.delete();
        @(negedge WR_CLK) START = 1'b1;
        @(negedge WR_CLK) START = 1'b0;
        idx = 0; cyc = 0;
        while (idx < n && cyc < 600 && !DONE) begin
            acc = 1'b0;
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                IN_VALID = 1'b0;
                IN_LAST  = 1'b0;
            end else begin
                IN_VALID = 1'b1;
                IN_BYTE  = stim_q[idx];
                IN_LAST  = (idx == last_idx);
                START    = (idx == start_at);
                acc      = IN_READY;
            end
            @(negedge WR_CLK);
            START = 1'b0;
            if (acc) idx = (idx == last_idx) ? n : idx + 1;
            cyc++;
        end
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
        cyc = 0;
        while (!DONE && cyc < 20) begin
            @(negedge WR_CLK);
            cyc++;
        end
        check_val({name, "_done"}, 32'(DONE), 32'd1);
        // Offer another byte: a finished loader must not take it
        IN_VALID = 1'b1;
        IN_BYTE  = 8'hEE;
        repeat (3) @(negedge WR_CLK);
        check_val({name, "_ready_after_done"}, 32'(IN_READY), 32'd0);
        IN_VALID = 1'b0;
        check_val({name, "_overflow"}, 32'(OVERFLOW), 32'(exp_ovf));
        check_val({name, "_word_count"}, 32'(WORD_COUNT), 32'(exp_q.size()));
        check_val({name, "_num_writes"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int w = 0; w < exp_q.size() && w < obs_q.size(); w++) begin
            $display("[TB] %s wr%0d addr=%0d data=%08h sel=%b (exp addr=%0d data=%08h sel=%b)",
                     name, w, obs_q[w].addr, obs_q[w].data, obs_q[w].sel,
                     exp_q[w].addr, exp_q[w].data, exp_q[w].sel);
            check_val($sformatf("%s_addr%0d", name, w), 32'(obs_q[w].addr), 32'(exp_q[w].addr));
            check_val($sformatf("%s_sel%0d", name, w), 32'(obs_q[w].sel), 32'(exp_q[w].sel));
            check_val($sformatf("%s_data%0d", name, w),
                      obs_q[w].data & byte_mask(exp_q[w].sel), exp_q[w].data & byte_mask(exp_q[w].sel));
        end
    endtask

    task automatic fill_seq(input int n, input logic [7:0] first);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(first + 8'(i));
    endtask

    initial begin
        int n;
        int last_idx;

        // Reset with a stream already presented
        ARST_N = 1'b0; IN_VALID = 1'b1; IN_BYTE = 8'h5A; IN_LAST = 1'b1;
        repeat (3) @(negedge WR_CLK);
        check_val("rst_ready", 32'(IN_READY), 32'd0);
        check_val("rst_wr_en", 32'(WR_EN), 32'd0);
        check_val("rst_addr", 32'(WR_ADDR), 32'd0);
        check_val("rst_data", WR_DATA, 32'd0);
        check_val("rst_sel", 32'(BYTE_SELECT), 32'd0);
        check_val("rst_count", 32'(WORD_COUNT), 32'd0);
        check_val("rst_done", 32'(DONE), 32'd0);
        check_val("rst_ovf", 32'(OVERFLOW), 32'd0);
        ARST_N = 1'b1;
        repeat (3) @(negedge WR_CLK);
        check_val("idle_ready", 32'(IN_READY), 32'd0);
        check_val("idle_no_write", 32'(obs_q.size()), 32'd0);
        IN_VALID = 1'b0; IN_LAST = 1'b0;

        fill_seq(8, 8'h01);
        do_load("full8", 7, 1'b0, -1);
        fill_seq(6, 8'hA0);
        do_load("part6", 5, 1'b0, -1);
        fill_seq(5, 8'hC0);
        do_load("last_lane0", 4, 1'b0, -1);
        fill_seq(40, 8'h40);
        do_load("ovf40", -1, 1'b0, -1);
        fill_seq(8, 8'h01);
        do_load("gaps8_start", 7, 1'b1, 5);

        // Reset after two bytes of a word: nothing may be written
        obs_q.delete();
        @(negedge WR_CLK) START = 1'b1;
        @(negedge WR_CLK) START = 1'b0; IN_VALID = 1'b1; IN_BYTE = 8'h77;
        @(negedge WR_CLK) IN_BYTE = 8'h78;
        @(negedge WR_CLK) IN_VALID = 1'b0; ARST_N = 1'b0;
        #1;
        check_val("midrst_sel", 32'(BYTE_SELECT), 32'd0);
        check_val("midrst_ready", 32'(IN_READY), 32'd0);
        @(negedge WR_CLK) ARST_N = 1'b1;
        repeat (4) @(negedge WR_CLK);
        check_val("midrst_no_write", 32'(obs_q.size()), 32'd0);
        fill_seq(4, 8'h11);
        do_load("after_rst", 3, 1'b0, -1);

        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                n = $urandom_range(33, 40);
                last_idx = -1;
            end else begin
                n = $urandom_range(1, 40);
                last_idx = $urandom_range(0, n - 1);
            end
            stim_q.delete();
            for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
            do_load($sformatf("rand%0d", it), last_idx, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 8));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
